// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter that shares one leaf-to-BFT output link among the user output streams,
// wrapping each granted word into a BFT packet under per-port destination credit.
module leaf_out_arbiter #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int NUM_OUT_PORTS = 7
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  input  logic                                  cfg_we,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dest_port,
  input  logic                                  credit_upd_vld,
  input  logic [NUM_PORT_BITS-1:0]              credit_upd_port,
  input  logic [NUM_ADDR_BITS:0]                credit_upd_cnt,
  input  logic                                  resend,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
  output logic [NUM_OUT_PORTS-1:0]              credit_empty
);

  localparam int PTR_W  = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int CRED_W = NUM_ADDR_BITS + 1;
  localparam logic [CRED_W-1:0] CRED_MAX = {1'b1, {NUM_ADDR_BITS{1'b0}}};

  typedef enum logic [1:0] {S_RUN, S_STALL, S_RESUME} state_t;

  state_t                   state, state_nxt;
  logic [PTR_W-1:0]         rr_ptr, rr_ptr_nxt;
  logic [NUM_OUT_PORTS-1:0] configured;
  logic [NUM_LEAF_BITS-1:0] dest_leaf [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dest_port [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr      [NUM_OUT_PORTS];
  logic [CRED_W-1:0]        credit    [NUM_OUT_PORTS];
  logic [CRED_W-1:0]        credit_nxt[NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] cfg_hit, upd_hit, eligible, grant;
  logic                     grant_vld;
  logic [PTR_W-1:0]         grant_idx;
  logic [PTR_W:0]           arb_idx;
  logic [PACKET_BITS-1:0]   dout_nxt, dout_p1;

  function automatic logic [CRED_W-1:0] sat_credit(input logic [CRED_W-1:0] cur,
                                                   input logic              dec,
                                                   input logic [CRED_W-1:0] inc);
    logic [CRED_W:0] sum;
    sum = {1'b0, cur} + {1'b0, inc} - {{CRED_W{1'b0}}, dec};
    return (sum > {1'b0, CRED_MAX}) ? CRED_MAX : sum[CRED_W-1:0];
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:    if (resend) state_nxt = S_STALL;
      S_STALL:  if (!resend) state_nxt = S_RESUME;
      S_RESUME: state_nxt = resend ? S_STALL : S_RUN;
      default:  state_nxt = S_RUN;
    endcase
  end

  // A resend sampled while running blocks the grant outright, so no credit or address is spent
  // on a packet that would be dropped anyway.
  always_comb begin
    cfg_hit  = '0;
    upd_hit  = '0;
    eligible = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      cfg_hit[i]  = cfg_we && (cfg_port == NUM_PORT_BITS'(i));
      upd_hit[i]  = credit_upd_vld && (credit_upd_port == NUM_PORT_BITS'(i));
      eligible[i] = vld_user2interface[i] && configured[i] && (credit[i] != '0) &&
                    (state == S_RUN) && !resend && !cfg_hit[i];
    end
  end

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    arb_idx   = '0;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      arb_idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (arb_idx >= (PTR_W+1)'(NUM_OUT_PORTS)) arb_idx = arb_idx - (PTR_W+1)'(NUM_OUT_PORTS);
      if (!grant_vld && eligible[arb_idx[PTR_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = arb_idx[PTR_W-1:0];
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (grant_vld)
      rr_ptr_nxt = (grant_idx == PTR_W'(NUM_OUT_PORTS - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_comb begin
    dout_nxt = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      if (grant[i])
        dout_nxt = {1'b1, dest_leaf[i], dest_port[i], addr[i],
                    din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
  end

  // Config write wins over grant and credit return on the same port.
  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      credit_nxt[i] = sat_credit(credit[i], grant[i], upd_hit[i] ? credit_upd_cnt : '0);
      if (cfg_hit[i]) credit_nxt[i] = CRED_MAX;
    end
  end

  // p0 -> p1: packet and per-port state registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_RUN;
      rr_ptr       <= '0;
      configured   <= '0;
      dout_p1      <= '0;
      credit_empty <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        dest_leaf[i] <= '0;
        dest_port[i] <= '0;
        addr[i]      <= '0;
        credit[i]    <= CRED_MAX;
      end
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_ptr_nxt;
      dout_p1 <= dout_nxt;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i]       <= credit_nxt[i];
        credit_empty[i] <= (credit_nxt[i] == '0);
        if (cfg_hit[i]) begin
          configured[i] <= 1'b1;
          dest_leaf[i]  <= cfg_dest_leaf;
          dest_port[i]  <= cfg_dest_port;
          addr[i]       <= '0;
        end else if (grant[i]) begin
          addr[i] <= addr[i] + 1'b1;
        end
      end
    end
  end

  assign ack_interface2user      = grant;
  assign dout_leaf_interface2bft = dout_p1;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed plus randomized bench for leaf_out_arbiter against a per-cycle behavioural model.
module tb_leaf_out_arbiter;

  localparam int N = 7;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*32-1:0] din;
  logic [N-1:0]    vld;
  logic [N-1:0]    ack;
  logic            cfg_we;
  logic [3:0]      cfg_port;
  logic [4:0]      cfg_dest_leaf;
  logic [3:0]      cfg_dest_port;
  logic            credit_upd_vld;
  logic [3:0]      credit_upd_port;
  logic [7:0]      credit_upd_cnt;
  logic            resend;
  logic [48:0]     dout;
  logic [N-1:0]    credit_empty;

  leaf_out_arbiter dut (
    .clk(clk), .reset(reset),
    .din_leaf_user2interface(din), .vld_user2interface(vld), .ack_interface2user(ack),
    .cfg_we(cfg_we), .cfg_port(cfg_port), .cfg_dest_leaf(cfg_dest_leaf), .cfg_dest_port(cfg_dest_port),
    .credit_upd_vld(credit_upd_vld), .credit_upd_port(credit_upd_port), .credit_upd_cnt(credit_upd_cnt),
    .resend(resend), .dout_leaf_interface2bft(dout), .credit_empty(credit_empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_cfg [N];
  int m_leaf[N];
  int m_dport[N];
  int m_addr[N];
  int m_cred[N];
  int m_ptr;
  int m_rs1, m_rs2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cfg[i] = 0; m_leaf[i] = 0; m_dport[i] = 0; m_addr[i] = 0; m_cred[i] = 128;
    end
    m_ptr = 0; m_rs1 = 0; m_rs2 = 0;
  endtask

  task automatic idle_inputs();
    vld = '0; cfg_we = 0; cfg_port = 0; cfg_dest_leaf = 0; cfg_dest_port = 0;
    credit_upd_vld = 0; credit_upd_port = 0; credit_upd_cnt = 0; resend = 0;
  endtask

  task automatic rand_din();
    for (int i = 0; i < N; i++) din[i*32 +: 32] = $urandom;
  endtask

  // One clock: inputs already driven just after the falling edge.
  task automatic cycle();
    int g;
    int p;
    logic [N-1:0]  exp_ack;
    logic [48:0]   exp_dout;
    logic [N-1:0]  exp_empty;
    g = -1;
    // Grants only when resend is low now and was low on the two previous cycles.
    if (!reset && !resend && !m_rs1 && !m_rs2)
      for (int k = 0; k < N; k++) begin
        p = (m_ptr + k) % N;
        if (g < 0 && vld[p] && m_cfg[p] != 0 && m_cred[p] > 0 && !(cfg_we && int'(cfg_port) == p))
          g = p;
      end
    exp_ack  = '0;
    exp_dout = '0;
    if (g >= 0) begin
      exp_ack[g] = 1'b1;
      exp_dout   = {1'b1, 5'(m_leaf[g]), 4'(m_dport[g]), 7'(m_addr[g]), din[g*32 +: 32]};
    end
    #2;
    if (!reset) check("ack", 64'(ack), 64'(exp_ack));
    if (reset) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        m_cred[g] -= 1;
        m_addr[g] = (m_addr[g] + 1) % 128;
        m_ptr = (g + 1) % N;
      end
      if (credit_upd_vld && int'(credit_upd_port) < N) begin
        m_cred[credit_upd_port] += int'(credit_upd_cnt);
        if (m_cred[credit_upd_port] > 128) m_cred[credit_upd_port] = 128;
      end
      if (cfg_we && int'(cfg_port) < N) begin
        m_cfg[cfg_port] = 1; m_leaf[cfg_port] = int'(cfg_dest_leaf);
        m_dport[cfg_port] = int'(cfg_dest_port); m_cred[cfg_port] = 128; m_addr[cfg_port] = 0;
      end
      m_rs2 = m_rs1;
      m_rs1 = int'(resend);
    end
    for (int i = 0; i < N; i++) exp_empty[i] = (m_cred[i] == 0);
    @(posedge clk);
    #1;
    check("dout", 64'(dout), 64'(exp_dout));
    check("credit_empty", 64'(credit_empty), 64'(exp_empty));
    @(negedge clk);
  endtask

  task automatic do_cfg(input int port, input int leaf, input int dport);
    cfg_we = 1; cfg_port = 4'(port); cfg_dest_leaf = 5'(leaf); cfg_dest_port = 4'(dport);
    cycle();
    cfg_we = 0;
  endtask

  initial begin
    idle_inputs();
    din = '0;
    reset = 1;
    model_reset();
    @(negedge clk);
    cycle();
    cycle();
    reset = 0;
    check("reset_ack", 64'(ack), 64'd0);
    check("reset_dout", 64'(dout), 64'd0);
    check("reset_empty", 64'(credit_empty), 64'd0);

    // Single port, fixed payload, address sequence
    do_cfg(0, 3, 2);
    vld = 7'b0000001;
    din[31:0] = 32'hA5A5_0001;
    cycle();
    check("first_pkt", 64'(dout), 64'({1'b1, 5'd3, 4'd2, 7'd0, 32'hA5A50001}));
    cycle();
    check("addr1", 64'(dout[38:32]), 64'd1);
    cycle();
    check("addr2", 64'(dout[38:32]), 64'd2);

    // Round robin across configured ports 0, 2, 6
    vld = '0;
    do_cfg(2, 4, 1);
    do_cfg(6, 17, 9);
    vld = '1;
    for (int c = 0; c < 8; c++) begin rand_din(); cycle(); end

    // Credit exhaustion on port 1, return, and saturation
    vld = '0;
    do_cfg(1, 8, 5);
    vld = 7'b0000010;
    for (int c = 0; c < 130; c++) begin rand_din(); cycle(); end
    check("port1_empty", 64'(credit_empty[1]), 64'd1);
    check("port1_no_ack", 64'(ack[1]), 64'd0);
    credit_upd_vld = 1; credit_upd_port = 4'd1; credit_upd_cnt = 8'd64;
    cycle();
    credit_upd_vld = 0;
    rand_din();
    cycle();
    check("port1_wrap_addr", 64'(dout[38:32]), 64'd0);
    for (int c = 0; c < 4; c++) begin rand_din(); cycle(); end
    credit_upd_vld = 1; credit_upd_port = 4'd1; credit_upd_cnt = 8'd200;
    cycle();
    credit_upd_vld = 0;
    for (int c = 0; c < 131; c++) begin rand_din(); cycle(); end

    // Resend stall during streaming
    vld = 7'b1000101;
    for (int c = 0; c < 3; c++) begin rand_din(); cycle(); end
    resend = 1;
    for (int c = 0; c < 5; c++) begin rand_din(); cycle(); end
    resend = 0;
    for (int c = 0; c < 6; c++) begin rand_din(); cycle(); end

    // Grant and credit return together; config write against a pending request
    vld = 7'b0000100;
    credit_upd_vld = 1; credit_upd_port = 4'd2; credit_upd_cnt = 8'd1;
    rand_din(); cycle();
    credit_upd_vld = 0;
    do_cfg(2, 7, 9);
    rand_din(); cycle();
    check("cfg_addr_reset", 64'(dout[38:32]), 64'd0);
    check("cfg_dest", 64'(dout[47:39]), 64'({5'd7, 4'd9}));

    // Randomized traffic, config writes, credit returns and resend pulses
    for (int c = 0; c < 400; c++) begin
      rand_din();
      vld = 7'($urandom);
      cfg_we = ($urandom_range(0, 15) == 0);
      cfg_port = 4'($urandom_range(0, 15));
      cfg_dest_leaf = 5'($urandom); cfg_dest_port = 4'($urandom);
      credit_upd_vld = ($urandom_range(0, 3) == 0);
      credit_upd_port = 4'($urandom_range(0, 8));
      credit_upd_cnt = 8'($urandom_range(0, 255));
      resend = ($urandom_range(0, 19) == 0);
      cycle();
    end
    idle_inputs();

    // Reset in the middle of streaming
    vld = '1;
    rand_din(); cycle();
    reset = 1;
    rand_din(); cycle();
    check("mid_reset_dout", 64'(dout), 64'd0);
    reset = 0;
    rand_din(); cycle();
    check("post_reset_ack", 64'(ack), 64'd0);
    check("post_reset_empty", 64'(credit_empty), 64'd0);
    do_cfg(4, 1, 1);
    for (int c = 0; c < 3; c++) begin rand_din(); cycle(); end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
